// File: rtl/irqc_pkg.sv
// Shared definitions for the peribus interrupt controller: register map,
// claim word layout, source limits and the handshake state type.
package irqc_pkg;

    localparam logic [1:0] ADDR_PENDING = 2'd0;
    localparam logic [1:0] ADDR_ENABLE  = 2'd1;
    localparam logic [1:0] ADDR_MODE    = 2'd2;
    localparam logic [1:0] ADDR_CLAIM   = 2'd3;

    localparam int CLAIM_VALID_BIT = 15;
    localparam int MAX_SRC         = 8;
    localparam int ID_W            = 3;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ASSERT  = 2'd1,
        ST_SERVICE = 2'd2
    } irqc_state_e;

    // Claim response: valid flag in the top bit, source id in the low bits
    function automatic logic [15:0] claim_word(input logic [ID_W-1:0] id);
        logic [15:0] word;
        word                  = 16'h0000;
        word[CLAIM_VALID_BIT] = 1'b1;
        word[ID_W-1:0]        = id;
        return word;
    endfunction

endpackage

// File: rtl/irqc_prio_enc.sv
// Fixed-priority encoder: reports the lowest-index set bit of the eligible
// vector and whether any bit is set at all.
module irqc_prio_enc
    import irqc_pkg::*;
#(
    parameter int N = MAX_SRC
) (
    input  logic [N-1:0]    eligible,
    output logic [ID_W-1:0] id,
    output logic            any_valid
);

    // Walk from the top index down so the lowest set index is the last one written
    always_comb begin
        id = {ID_W{1'b0}};
        for (int i = N - 1; i >= 0; i--) begin
            id = eligible[i] ? ID_W'(i) : id;
        end
        any_valid = |eligible;
    end

endmodule

// File: rtl/irq_controller.sv
// Peribus interrupt controller: pending/enable/mode registers, claim and
// end-of-interrupt handshake, single registered interrupt line to the CPU.
module irq_controller
    import irqc_pkg::*;
#(
    parameter int N_SRC = 8
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic [1:0]       addr,
    input  logic [15:0]      write_data,
    input  logic             write_en,
    input  logic             read_en,
    input  logic             chipselect,
    input  logic [N_SRC-1:0] irq_in,
    output logic [15:0]      read_data,
    output logic             irq_out
);

    logic [N_SRC-1:0] pending_r;
    logic [N_SRC-1:0] enable_r;
    logic [N_SRC-1:0] mode_r;
    logic [N_SRC-1:0] irq_prev_r;
    logic [ID_W-1:0]  claim_id_r;
    logic [15:0]      read_data_r;
    logic             irq_out_r;
    irqc_state_e      state_r;

    logic             bus_rd_s;
    logic             bus_wr_s;
    logic             claim_take_s;
    logic             eoi_s;
    logic [N_SRC-1:0] eligible_s;
    logic [N_SRC-1:0] rise_s;
    logic [N_SRC-1:0] w1c_s;
    logic [N_SRC-1:0] claim_clr_s;
    logic [N_SRC-1:0] mode_chg_s;
    logic [N_SRC-1:0] pending_next_s;
    logic [ID_W-1:0]  win_id_s;
    logic             win_valid_s;
    logic [15:0]      read_next_s;
    logic             unused_wdata_s;

    assign bus_rd_s       = chipselect && read_en;
    assign bus_wr_s       = chipselect && write_en;
    assign eligible_s     = pending_r & enable_r;
    assign rise_s         = irq_in & ~irq_prev_r;
    assign w1c_s          = (bus_wr_s && (addr == ADDR_PENDING)) ? write_data[N_SRC-1:0] : {N_SRC{1'b0}};
    assign mode_chg_s     = (bus_wr_s && (addr == ADDR_MODE)) ? (write_data[N_SRC-1:0] ^ mode_r) : {N_SRC{1'b0}};
    assign claim_take_s   = bus_rd_s && (addr == ADDR_CLAIM) && (state_r == ST_ASSERT) && win_valid_s;
    assign eoi_s          = bus_wr_s && (addr == ADDR_CLAIM) && (state_r == ST_SERVICE);
    assign unused_wdata_s = ^write_data;
    assign read_data      = read_data_r;
    assign irq_out        = irq_out_r;

    irqc_prio_enc #(
        .N (N_SRC)
    ) u_prio_enc (
        .eligible  (eligible_s),
        .id        (win_id_s),
        .any_valid (win_valid_s)
    );

    // Decode which source a successful claim retires
    always_comb begin
        claim_clr_s = {N_SRC{1'b0}};
        for (int i = 0; i < N_SRC; i++) begin
            claim_clr_s[i] = claim_take_s && (win_id_s == ID_W'(i));
        end
    end

    // Next pending value per source: mode change clears, level follows input, edge sets over clears
    always_comb begin
        pending_next_s = pending_r;
        for (int i = 0; i < N_SRC; i++) begin
            if (mode_chg_s[i]) begin
                pending_next_s[i] = 1'b0;
            end else if (!mode_r[i]) begin
                pending_next_s[i] = irq_in[i];
            end else if (rise_s[i]) begin
                pending_next_s[i] = 1'b1;
            end else if (w1c_s[i] || claim_clr_s[i]) begin
                pending_next_s[i] = 1'b0;
            end else begin
                pending_next_s[i] = pending_r[i];
            end
        end
    end

    // Read mux; the claim view depends on where the handshake currently is
    always_comb begin
        read_next_s = read_data_r;
        if (bus_rd_s) begin
            case (addr)
                ADDR_PENDING: read_next_s = 16'(pending_r);
                ADDR_ENABLE:  read_next_s = 16'(enable_r);
                ADDR_MODE:    read_next_s = 16'(mode_r);
                ADDR_CLAIM: begin
                    case (state_r)
                        ST_ASSERT:  read_next_s = win_valid_s ? claim_word(win_id_s) : 16'h0000;
                        ST_SERVICE: read_next_s = claim_word(claim_id_r);
                        default:    read_next_s = 16'h0000;
                    endcase
                end
                default:      read_next_s = 16'h0000;
            endcase
        end else begin
            read_next_s = read_data_r;
        end
    end

    // Source-side registers: edge history, pending, enable and mode
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            irq_prev_r <= {N_SRC{1'b0}};
            pending_r  <= {N_SRC{1'b0}};
            enable_r   <= {N_SRC{1'b0}};
            mode_r     <= {N_SRC{1'b0}};
        end else begin
            irq_prev_r <= irq_in;
            pending_r  <= pending_next_s;
            if (bus_wr_s && (addr == ADDR_ENABLE)) begin
                enable_r <= write_data[N_SRC-1:0];
            end else begin
                enable_r <= enable_r;
            end
            if (bus_wr_s && (addr == ADDR_MODE)) begin
                mode_r <= write_data[N_SRC-1:0];
            end else begin
                mode_r <= mode_r;
            end
        end
    end

    // Handshake FSM with registered irq_out, claimed id latch and bus read data
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_r     <= ST_IDLE;
            irq_out_r   <= 1'b0;
            claim_id_r  <= {ID_W{1'b0}};
            read_data_r <= 16'h0000;
        end else begin
            read_data_r <= read_next_s;
            case (state_r)
                ST_IDLE: begin
                    if (win_valid_s) begin
                        state_r   <= ST_ASSERT;
                        irq_out_r <= 1'b1;
                    end else begin
                        state_r   <= ST_IDLE;
                        irq_out_r <= 1'b0;
                    end
                end
                ST_ASSERT: begin
                    if (claim_take_s) begin
                        state_r    <= ST_SERVICE;
                        irq_out_r  <= 1'b0;
                        claim_id_r <= win_id_s;
                    end else if (!win_valid_s) begin
                        state_r   <= ST_IDLE;
                        irq_out_r <= 1'b0;
                    end else begin
                        state_r   <= ST_ASSERT;
                        irq_out_r <= 1'b1;
                    end
                end
                ST_SERVICE: begin
                    irq_out_r <= 1'b0;
                    if (eoi_s) begin
                        state_r <= ST_IDLE;
                    end else begin
                        state_r <= ST_SERVICE;
                    end
                end
                default: begin
                    state_r   <= ST_IDLE;
                    irq_out_r <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_irq_controller.sv
// Self-checking bench for irq_controller: directed handshake scenarios plus
// randomized bus/source traffic compared against a behavioural model.
module tb_irq_controller;

    localparam int N = 8;

    logic         clock;
    logic         reset_n;
    logic [1:0]   addr;
    logic [15:0]  write_data;
    logic         write_en;
    logic         read_en;
    logic         chipselect;
    logic [N-1:0] irq_in;
    logic [15:0]  read_data;
    logic         irq_out;

    int vectors     = 0;
    int miscompares = 0;

    // Behavioural model: phase 0 = quiet, 1 = line raised, 2 = handler running
    logic [7:0]  m_pend, m_en, m_mode, m_prev;
    int          m_phase;
    int          m_id;
    logic [15:0] m_rdata;
    logic        m_irq;

    irq_controller #(.N_SRC(N)) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .addr       (addr),
        .write_data (write_data),
        .write_en   (write_en),
        .read_en    (read_en),
        .chipselect (chipselect),
        .irq_in     (irq_in),
        .read_data  (read_data),
        .irq_out    (irq_out)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic model_reset();
        m_pend = 8'h00; m_en = 8'h00; m_mode = 8'h00; m_prev = 8'h00;
        m_phase = 0; m_id = 0; m_rdata = 16'h0000; m_irq = 1'b0;
    endtask

    task automatic model_step();
        logic [7:0] elig;
        logic [7:0] nxt;
        int  win;
        bit  rd, wr, took;
        elig = m_pend & m_en;
        win  = -1;
        for (int i = 0; i < N; i++) begin
            if (elig[i]) begin
                win = i;
                break;
            end
        end
        rd   = chipselect && read_en;
        wr   = chipselect && write_en;
        took = rd && (addr == 2'd3) && (m_phase == 1) && (win >= 0);
        if (rd) begin
            case (addr)
                2'd0:    m_rdata = {8'h00, m_pend};
                2'd1:    m_rdata = {8'h00, m_en};
                2'd2:    m_rdata = {8'h00, m_mode};
                default: begin
                    if (m_phase == 1 && win >= 0) m_rdata = 16'h8000 + 16'(win);
                    else if (m_phase == 2)        m_rdata = 16'h8000 + 16'(m_id);
                    else                          m_rdata = 16'h0000;
                end
            endcase
        end
        for (int i = 0; i < N; i++) begin
            if (wr && addr == 2'd2 && write_data[i] != m_mode[i]) nxt[i] = 1'b0;
            else if (!m_mode[i])                                  nxt[i] = irq_in[i];
            else if (irq_in[i] && !m_prev[i])                     nxt[i] = 1'b1;
            else if ((wr && addr == 2'd0 && write_data[i]) || (took && win == i)) nxt[i] = 1'b0;
            else                                                  nxt[i] = m_pend[i];
        end
        if (m_phase == 0) begin
            if (elig != 8'h00) m_phase = 1;
        end else if (m_phase == 1) begin
            if (took) begin
                m_phase = 2;
                m_id    = win;
            end else if (elig == 8'h00) begin
                m_phase = 0;
            end
        end else begin
            if (wr && addr == 2'd3) m_phase = 0;
        end
        m_pend = nxt;
        m_prev = irq_in;
        if (wr && addr == 2'd1) m_en   = write_data[7:0];
        if (wr && addr == 2'd2) m_mode = write_data[7:0];
        m_irq = (m_phase == 1);
    endtask

    task automatic tick();
        @(posedge clock);
        model_step();
        #1;
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [15:0] d);
        addr = a; write_data = d; chipselect = 1'b1; write_en = 1'b1;
        tick();
        write_en = 1'b0; chipselect = 1'b0;
    endtask

    task automatic bus_read(input logic [1:0] a);
        addr = a; chipselect = 1'b1; read_en = 1'b1;
        tick();
        read_en = 1'b0; chipselect = 1'b0;
    endtask

    task automatic do_reset();
        reset_n = 1'b0; addr = 2'd0; write_data = 16'h0000;
        write_en = 1'b0; read_en = 1'b0; chipselect = 1'b0; irq_in = 8'h00;
        #1;
        model_reset();
        @(negedge clock);
        reset_n = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        reset_n = 1'b0; addr = 2'd0; write_data = 16'h0000;
        write_en = 1'b0; read_en = 1'b0; chipselect = 1'b0; irq_in = 8'h00;
        #12;
        vectors++;
        if (read_data !== 16'h0000) begin
            miscompares++; $display("FAIL reset_rdata: got %h want 0000", read_data);
        end
        vectors++;
        if (irq_out !== 1'b0) begin
            miscompares++; $display("FAIL reset_irq: got %b want 0", irq_out);
        end
        do_reset();
    endtask

    task automatic test_timer_level();
        do_reset();
        bus_write(2'd2, 16'h0000);
        bus_write(2'd1, 16'h0001);
        irq_in = 8'h01;
        tick();
        vectors++;
        if (irq_out !== 1'b0) begin
            miscompares++; $display("FAIL timer_early: irq_out=%b want 0", irq_out);
        end
        tick();
        vectors++;
        if (irq_out !== 1'b1) begin
            miscompares++; $display("FAIL timer_assert: irq_out=%b want 1", irq_out);
        end
        bus_read(2'd3);
        vectors++;
        if (read_data !== 16'h8000) begin
            miscompares++; $display("FAIL timer_claim: got %h want 8000", read_data);
        end
        vectors++;
        if (irq_out !== 1'b0) begin
            miscompares++; $display("FAIL timer_claim_irq: irq_out=%b want 0", irq_out);
        end
        bus_read(2'd3);
        vectors++;
        if (read_data !== 16'h8000) begin
            miscompares++; $display("FAIL timer_reclaim: got %h want 8000", read_data);
        end
        bus_write(2'd3, 16'h0000);
        tick();
        vectors++;
        if (irq_out !== 1'b1) begin
            miscompares++; $display("FAIL timer_eoi_reassert: irq_out=%b want 1", irq_out);
        end
    endtask

    task automatic test_edge();
        do_reset();
        bus_write(2'd2, 16'h0004);
        bus_write(2'd1, 16'h0004);
        irq_in = 8'h04;
        tick();
        irq_in = 8'h00;
        bus_read(2'd0);
        vectors++;
        if (read_data !== 16'h0004) begin
            miscompares++; $display("FAIL edge_pending: got %h want 0004", read_data);
        end
        bus_read(2'd3);
        vectors++;
        if (read_data !== 16'h8002) begin
            miscompares++; $display("FAIL edge_claim: got %h want 8002", read_data);
        end
        bus_read(2'd0);
        vectors++;
        if (read_data !== 16'h0000) begin
            miscompares++; $display("FAIL edge_cleared: got %h want 0000", read_data);
        end
    endtask

    task automatic test_priority();
        do_reset();
        bus_write(2'd1, 16'h00FF);
        bus_write(2'd2, 16'h00FF);
        irq_in = 8'h28;
        tick();
        irq_in = 8'h00;
        tick();
        bus_read(2'd3);
        vectors++;
        if (read_data !== 16'h8003) begin
            miscompares++; $display("FAIL prio_first: got %h want 8003", read_data);
        end
        bus_write(2'd3, 16'h0000);
        tick();
        vectors++;
        if (irq_out !== 1'b1) begin
            miscompares++; $display("FAIL prio_reassert: irq_out=%b want 1", irq_out);
        end
        bus_read(2'd3);
        vectors++;
        if (read_data !== 16'h8005) begin
            miscompares++; $display("FAIL prio_second: got %h want 8005", read_data);
        end
    endtask

    task automatic test_set_wins();
        do_reset();
        bus_write(2'd2, 16'h0002);
        bus_write(2'd1, 16'h0002);
        irq_in = 8'h02;
        bus_write(2'd0, 16'h0002);
        bus_read(2'd0);
        vectors++;
        if (read_data !== 16'h0002) begin
            miscompares++; $display("FAIL set_wins: got %h want 0002", read_data);
        end
        bus_write(2'd0, 16'h0002);
        bus_read(2'd0);
        vectors++;
        if (read_data !== 16'h0000) begin
            miscompares++; $display("FAIL w1c: got %h want 0000", read_data);
        end
        bus_write(2'd2, 16'h0000);
        bus_write(2'd0, 16'h0002);
        bus_read(2'd0);
        vectors++;
        if (read_data !== 16'h0002) begin
            miscompares++; $display("FAIL level_ignores_w1c: got %h want 0002", read_data);
        end
    endtask

    task automatic test_claim_idle_and_reset();
        do_reset();
        bus_read(2'd3);
        vectors++;
        if (read_data !== 16'h0000) begin
            miscompares++; $display("FAIL claim_idle: got %h want 0000", read_data);
        end
        bus_write(2'd1, 16'h0001);
        irq_in = 8'h01;
        tick();
        tick();
        bus_read(2'd3);
        vectors++;
        if (read_data !== 16'h8000) begin
            miscompares++; $display("FAIL svc_claim: got %h want 8000", read_data);
        end
        irq_in = 8'h00;
        #2;
        reset_n = 1'b0;
        #1;
        model_reset();
        vectors++;
        if (read_data !== 16'h0000 || irq_out !== 1'b0) begin
            miscompares++; $display("FAIL async_reset: rdata=%h irq=%b want 0000/0", read_data, irq_out);
        end
        @(negedge clock);
        reset_n = 1'b1;
        tick();
        for (int a = 0; a < 4; a++) begin
            bus_read(2'(a));
            vectors++;
            if (read_data !== 16'h0000 || irq_out !== 1'b0) begin
                miscompares++;
                $display("FAIL post_reset_reg%0d: rdata=%h irq=%b want 0000/0", a, read_data, irq_out);
            end
        end
        irq_in = 8'h01;
        for (int c = 0; c < 4; c++) tick();
        vectors++;
        if (irq_out !== 1'b0) begin
            miscompares++; $display("FAIL post_reset_quiet: irq_out=%b want 0", irq_out);
        end
        bus_write(2'd1, 16'h0001);
        tick();
        vectors++;
        if (irq_out !== 1'b1) begin
            miscompares++; $display("FAIL reenable: irq_out=%b want 1", irq_out);
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 1500; c++) begin
            chipselect = ($urandom_range(0, 3) != 0);
            read_en    = 1'($urandom_range(0, 1));
            write_en   = ($urandom_range(0, 3) == 0);
            addr       = 2'($urandom_range(0, 3));
            write_data = 16'($urandom);
            if ($urandom_range(0, 3) == 0) irq_in = 8'($urandom);
            tick();
            vectors++;
            if (read_data !== m_rdata) begin
                miscompares++; $display("FAIL rand_rdata cyc %0d: got %h want %h", c, read_data, m_rdata);
            end
            vectors++;
            if (irq_out !== m_irq) begin
                miscompares++; $display("FAIL rand_irq cyc %0d: got %b want %b", c, irq_out, m_irq);
            end
        end
        chipselect = 1'b0; read_en = 1'b0; write_en = 1'b0;
    endtask

    initial begin
        test_reset();
        test_timer_level();
        test_edge();
        test_priority();
        test_set_wins();
        test_claim_idle_and_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/irq_controller.md
IRQ_CONTROLLER -- requirements
Module: irq_controller

Interface
REQ-001 SHALL have parameter N_SRC, default 8, number of interrupt sources (legal 1..8).
REQ-002 SHALL have port clock  input  1  sole clock; all state updates on its rising edge.
REQ-003 SHALL have port reset_n  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have port addr  input  2  peribus register select.
REQ-005 SHALL have port write_data  input  16  peribus write data.
REQ-006 SHALL have port write_en  input  1  peribus write strobe, qualified by chipselect.
REQ-007 SHALL have port read_en  input  1  peribus read strobe, qualified by chipselect.
REQ-008 SHALL have port chipselect  input  1  peribus select for this block.
REQ-009 SHALL have port irq_in  input  N_SRC  source requests, synchronous to clock; bit 0 is the system timer irq.
REQ-010 SHALL have port read_data  output  16  registered peribus read data.
REQ-011 SHALL have port irq_out  output  1  registered interrupt request to the CPU.

Function
REQ-012 SHALL map registers: 0 PENDING (read; write-1-to-clear), 1 ENABLE (r/w), 2 MODE (r/w; 1 = rising-edge, 0 = level), 3 CLAIM (read = claim, write = end-of-interrupt); bits [15:N_SRC] read 0 and ignore writes.
REQ-013 SHALL update read_data one cycle after chipselect && read_en and hold it otherwise.
REQ-014 Edge source: pending bit SHALL set on the cycle after irq_in rises (irq_in && !irq_prev); it SHALL clear on a PENDING write-1 or on a claim of that source; a set and a clear in the same cycle SHALL leave it set.
REQ-015 Level source: pending bit SHALL equal irq_in delayed one cycle; PENDING writes SHALL have no effect on it.
REQ-016 A MODE write SHALL clear the pending bit of every source whose mode bit changes.
REQ-017 Eligible set SHALL be PENDING & ENABLE; the winner SHALL be its lowest-index set bit.
REQ-018 SHALL implement FSM IDLE, ASSERT, SERVICE; irq_out SHALL be 1 exactly when state is ASSERT.
REQ-019 IDLE -> ASSERT when the eligible set is non-zero.
REQ-020 ASSERT -> IDLE when the eligible set becomes zero before a claim.
REQ-021 ASSERT -> SERVICE on a CLAIM read; the block SHALL latch the winner id and return {1'b1, 12'h0, id[2:0]}.
REQ-022 A CLAIM read in IDLE SHALL return 16'h0000 and change no state.
REQ-023 A CLAIM read in SERVICE SHALL return the latched id with bit 15 = 1 and have no side effect.
REQ-024 SERVICE -> IDLE on any write to addr 3; a write to addr 3 outside SERVICE SHALL be ignored.
REQ-025 In SERVICE, new requests SHALL accumulate in PENDING while irq_out stays 0; there is no nesting.
REQ-026 Bus writes SHALL take precedence over internal updates of the same register bit, except for the REQ-014 set-wins rule.

Reset
REQ-027 On reset_n low, the block SHALL immediately clear PENDING, ENABLE, MODE, irq_prev, the latched id, read_data and irq_out, and set state to IDLE.
REQ-028 Reset asserted mid-SERVICE SHALL abandon the claim; after release, no interrupt SHALL be asserted until a source is re-enabled and pending.

Structure
REQ-029 The shared package irqc_pkg SHALL hold the register address constants, the CLAIM valid bit offset, the maximum source count, and the FSM state enum type.
REQ-030 The lowest-index winner selection SHALL be a sub-module irqc_prio_enc (inputs: eligible vector; outputs: id and any-valid).

Verification
REQ-031 Run the timer-level path: MODE=0, ENABLE=0x01, irq_in[0]=1. Required: irq_out=1 two cycles later; CLAIM read returns 0x8000; irq_out=0; EOI while irq_in[0] is still 1 re-asserts irq_out.
REQ-032 Run the edge path: MODE=0x04, ENABLE=0x04, one-cycle pulse on irq_in[2]. Required: PENDING=0x04; CLAIM read returns 0x8002; PENDING then reads 0x00.
REQ-033 Run priority: ENABLE=0xFF, MODE=0xFF, pulse irq_in[5] and irq_in[3] in the same cycle. Required: first CLAIM returns 0x8003; after EOI, irq_out=1 and the second CLAIM returns 0x8005.
REQ-034 Run set-wins: MODE=0x02, ENABLE=0x02, write PENDING=0x02 in the same cycle the irq_in[1] edge is detected. Required: PENDING=0x02.
REQ-035 Run claim outside ASSERT and reset in service: a CLAIM read in IDLE returns 0x0000. Assert reset_n in SERVICE. Required: all registers read 0 and irq_out=0 after release.
